// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide sequencer.
// Operation encodings match the Funct3 field of OP/MULDIV instructions.
package mdu_pkg;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic op_is_div(input m_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input m_op_e op);
        return op[2] & op[1];
    endfunction

    // MUL's low half is sign-agnostic, so treating it as signed x signed is harmless.
    function automatic logic op_is_a_signed(input m_op_e op);
        return op inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM};
    endfunction

    function automatic logic op_is_b_signed(input m_op_e op);
        return op inside {M_MUL, M_MULH, M_DIV, M_REM};
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: magnitudes are iterated one bit per
// cycle in a shared 2*XLEN accumulator, then sign-fixed and presented with done.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q, state_d;
    m_op_e             op_q, op_in;
    logic              a_neg_q, b_neg_q, b_zero_q;
    logic [2*XLEN-1:0] acc_q, acc_step;
    logic [XLEN-1:0]   mcand_q, pend_q, result_q;
    logic [CW-1:0]     cnt_q;

    logic              accept, a_neg_in, b_neg_in, fast_hit;
    logic [XLEN-1:0]   abs_a, abs_b, fast_val;

    // Request decode, operand magnitudes and the early-out shortcut values.
    always_comb begin
        op_in    = m_op_e'(Funct3);
        accept   = (state_q == IDLE) && start && !flush;
        a_neg_in = op_is_a_signed(op_in) && op_a[XLEN-1];
        b_neg_in = op_is_b_signed(op_in) && op_b[XLEN-1];
        abs_a    = a_neg_in ? -op_a : op_a;
        abs_b    = b_neg_in ? -op_b : op_b;
        fast_hit = 1'b0;
        fast_val = '0;
        if (EARLY_OUT && op_is_div(op_in)) begin
            if (op_b == '0) begin
                fast_hit = 1'b1;
                fast_val = op_is_rem(op_in) ? op_a : '1;
            end else if (op_is_b_signed(op_in) && (op_a == MIN_NEG) && (op_b == '1)) begin
                fast_hit = 1'b1;
                fast_val = op_is_rem(op_in) ? '0 : op_a;
            end
        end
    end

    logic [XLEN:0] mul_sum, div_trial, div_diff;

    // Upper half is the partial product (multiply) or partial remainder (divide);
    // the lower half shifts out multiplier bits or shifts in quotient bits.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + ({(XLEN+1){acc_q[0]}} & {1'b0, mcand_q});
        div_trial = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_trial - {1'b0, mcand_q};
        if (op_is_div(op_q)) begin
            if (!div_diff[XLEN]) begin
                acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    // A zero divisor keeps the all-ones quotient regardless of the dividend's sign.
    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quo_fix  = ((a_neg_q ^ b_neg_q) && !b_zero_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            M_MUL:                     fix_val = prod_fix[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:             fix_val = quo_fix;
            default:                   fix_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CALC holds one extra cycle at LAST_CNT after the final step before FIX.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = fast_hit ? DONE : CALC;
            CALC: if (cnt_q == LAST_CNT) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= M_MUL;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= op_in;
                a_neg_q  <= a_neg_in;
                b_neg_q  <= b_neg_in;
                b_zero_q <= (op_b == '0);
                acc_q    <= {{XLEN{1'b0}}, abs_a};
                mcand_q  <= abs_b;
                cnt_q    <= '0;
                if (fast_hit) pend_q <= fast_val;
            end else if ((state_q == CALC) && (cnt_q != LAST_CNT)) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + CW'(1);
            end else if (state_q == FIX) begin
                pend_q <= fix_val;
            end
            if ((state_q == DONE) && !flush) result_q <= pend_q;
        end
    end

    // The finished value is visible during the done cycle itself; a flush there
    // drops it so the previously delivered result stays on the port.
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE) && !flush;
    assign result = done ? pend_q : result_q;

endmodule
